// File: rtl/jpegls_pkg.sv
// Shared constants and types for the JPEG-LS context/prediction front end.
// Holds alphabet limits, gradient thresholds, widths and stage bundles.
package jpegls_pkg;

    localparam int MAXVAL = 255;
    localparam int RANGE  = 256;
    localparam int T1     = 3;
    localparam int T2     = 7;
    localparam int T3     = 21;
    localparam int PIX_W  = 16;
    localparam int CTX_W  = 9;

    typedef logic signed [3:0] qgrad_t;

    typedef struct packed {
        logic             valid;
        qgrad_t           q1;
        qgrad_t           q2;
        qgrad_t           q3;
        logic [PIX_W-1:0] mn;
        logic [PIX_W-1:0] mx;
        logic [PIX_W-1:0] ra;
        logic [PIX_W-1:0] rb;
        logic [PIX_W-1:0] rc;
        logic [PIX_W-1:0] rx;
        logic             run;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic [CTX_W-1:0] ctx_q;
        logic             sign;
        logic [PIX_W-1:0] px;
        logic [PIX_W-1:0] rx;
        logic [PIX_W-1:0] ra;
        logic             run;
    } s2_t;

endpackage

// File: rtl/grad_quant.sv
// Combinational gradient quantizer: one signed Di -> Qi in -4..4.
// Ports: d (16-bit two's-complement gradient), q (signed 4-bit level).
import jpegls_pkg::*;

module grad_quant (
    input  logic [PIX_W-1:0] d,
    output qgrad_t           q
);

    localparam logic signed [PIX_W-1:0] P1 = PIX_W'(T1);
    localparam logic signed [PIX_W-1:0] P2 = PIX_W'(T2);
    localparam logic signed [PIX_W-1:0] P3 = PIX_W'(T3);
    localparam logic signed [PIX_W-1:0] Z  = '0;

    logic signed [PIX_W-1:0] ds;
    assign ds = signed'(d);

    // Bands are written as disjoint intervals so exactly one arm matches.
    always_comb begin
        q = '0;
        unique case (1'b1)
            (ds <= -P3):             q = qgrad_t'(-4);
            (ds > -P3 && ds <= -P2): q = qgrad_t'(-3);
            (ds > -P2 && ds <= -P1): q = qgrad_t'(-2);
            (ds > -P1 && ds < Z):    q = qgrad_t'(-1);
            (ds == Z):               q = qgrad_t'(0);
            (ds > Z && ds < P1):     q = qgrad_t'(1);
            (ds >= P1 && ds < P2):   q = qgrad_t'(2);
            (ds >= P2 && ds < P3):   q = qgrad_t'(3);
            default:                 q = qgrad_t'(4);
        endcase
    end

endmodule

// File: rtl/jpegls_ctx_pred.sv
// JPEG-LS context modelling + MED prediction, 3-stage valid-only pipeline.
// In: clk, rst, in_valid, rx/ra/rb/rc pixels, d1/d2/d3 gradients.
// Out: ctx_q, ctx_sign, px, errval, ra_out, run_mode, out_valid, eof.
import jpegls_pkg::*;

module jpegls_ctx_pred #(
    parameter int IMAGE_W = 256,
    parameter int IMAGE_H = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] rx,
    input  logic [PIX_W-1:0] ra,
    input  logic [PIX_W-1:0] rb,
    input  logic [PIX_W-1:0] rc,
    input  logic [PIX_W-1:0] d1,
    input  logic [PIX_W-1:0] d2,
    input  logic [PIX_W-1:0] d3,
    output logic [CTX_W-1:0] ctx_q,
    output logic             ctx_sign,
    output logic [PIX_W-1:0] px,
    output logic [PIX_W-1:0] errval,
    output logic [PIX_W-1:0] ra_out,
    output logic             run_mode,
    output logic             out_valid,
    output logic             eof
);

    localparam int NPIX = IMAGE_W * IMAGE_H;
    localparam int CW   = $clog2(NPIX + 1);

    localparam logic signed [PIX_W-1:0] RNG  = PIX_W'(RANGE);
    localparam logic signed [PIX_W-1:0] HALF = PIX_W'(RANGE / 2);

    // ---------------- stage 1: quantize, min/max, run flag
    qgrad_t qa, qb, qc;

    grad_quant u_q1 (.d(d1), .q(qa));
    grad_quant u_q2 (.d(d2), .q(qb));
    grad_quant u_q3 (.d(d3), .q(qc));

    s1_t s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
        end else begin
            s1.valid <= in_valid;
            if (in_valid) begin
                s1.q1  <= qa;
                s1.q2  <= qb;
                s1.q3  <= qc;
                s1.mn  <= (ra < rb) ? ra : rb;
                s1.mx  <= (ra < rb) ? rb : ra;
                s1.ra  <= ra;
                s1.rb  <= rb;
                s1.rc  <= rc;
                s1.rx  <= rx;
                s1.run <= (d1 == '0) && (d2 == '0) && (d3 == '0);
            end
        end
    end

    // ---------------- stage 2: sign merge, context index, MED
    logic             neg;
    qgrad_t           n1, n2, n3;
    logic [CTX_W-1:0] ctx_c;
    logic [PIX_W-1:0] px_c;

    always_comb begin
        neg = (s1.q1 < 0) ||
              (s1.q1 == 0 && s1.q2 < 0) ||
              (s1.q1 == 0 && s1.q2 == 0 && s1.q3 < 0);
        n1  = neg ? -s1.q1 : s1.q1;
        n2  = neg ? -s1.q2 : s1.q2;
        n3  = neg ? -s1.q3 : s1.q3;
        // Mod-512 arithmetic is exact: the merged index never leaves 0..364.
        ctx_c = CTX_W'(81) * CTX_W'(n1)
              + CTX_W'(9) * CTX_W'(n2)
              + CTX_W'(n3);
        // The planar term lies between min and max, so 16-bit wrap is exact.
        px_c = s1.ra + s1.rb - s1.rc;
        if (s1.rc >= s1.mx) begin
            px_c = s1.mn;
        end else if (s1.rc <= s1.mn) begin
            px_c = s1.mx;
        end
    end

    s2_t s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2 <= '0;
        end else begin
            s2.valid <= s1.valid;
            if (s1.valid) begin
                s2.ctx_q <= ctx_c;
                s2.sign  <= neg;
                s2.px    <= px_c;
                s2.rx    <= s1.rx;
                s2.ra    <= s1.ra;
                s2.run   <= s1.run;
            end
        end
    end

    // ---------------- stage 3: modulo-reduced error, frame count
    logic signed [PIX_W-1:0] e0, e1, e2, e3;

    always_comb begin
        e0 = signed'(s2.rx - s2.px);
        e1 = s2.sign ? -e0 : e0;
        e2 = (e1 < 0) ? e1 + RNG : e1;
        e3 = (e2 >= HALF) ? e2 - RNG : e2;
    end

    logic [CW-1:0] cnt;
    logic          last;

    assign last = (cnt == CW'(NPIX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            eof       <= 1'b0;
            ctx_q     <= '0;
            ctx_sign  <= 1'b0;
            px        <= '0;
            errval    <= '0;
            ra_out    <= '0;
            run_mode  <= 1'b0;
            cnt       <= '0;
        end else begin
            out_valid <= s2.valid;
            eof       <= s2.valid && last;
            if (s2.valid) begin
                ctx_q    <= s2.ctx_q;
                ctx_sign <= s2.sign;
                px       <= s2.px;
                errval   <= e3;
                ra_out   <= s2.ra;
                run_mode <= s2.run;
                cnt      <= last ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_jpegls_ctx_pred.sv
// Bench for jpegls_ctx_pred on a 4x4 frame: directed and random pixels,
// expected results queued at drive time and popped when out_valid rises.
module tb_jpegls_ctx_pred;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] rx, ra, rb, rc, d1, d2, d3;
    logic [8:0]  ctx_q;
    logic        ctx_sign;
    logic [15:0] px, errval, ra_out;
    logic        run_mode, out_valid, eof;

    jpegls_ctx_pred #(.IMAGE_W(W), .IMAGE_H(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .rx(rx), .ra(ra), .rb(rb), .rc(rc),
        .d1(d1), .d2(d2), .d3(d3),
        .ctx_q(ctx_q), .ctx_sign(ctx_sign), .px(px),
        .errval(errval), .ra_out(ra_out), .run_mode(run_mode),
        .out_valid(out_valid), .eof(eof)
    );

    typedef struct {
        logic [8:0]  ctx;
        logic        sg;
        logic [15:0] p;
        logic [15:0] ev;
        logic [15:0] a;
        logic        run;
        logic        eof;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   pix   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (out_valid === 1'b1) begin
                chk("spurious_valid", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ctx_q",    32'(ctx_q),    32'(e.ctx));
                    chk("ctx_sign", 32'(ctx_sign), 32'(e.sg));
                    chk("px",       32'(px),       32'(e.p));
                    chk("errval",   32'(errval),   32'(e.ev));
                    chk("ra_out",   32'(ra_out),   32'(e.a));
                    chk("run_mode", 32'(run_mode), 32'(e.run));
                    chk("eof",      32'(eof),      32'(e.eof));
                    chk("latency",  32'(cyc),      32'(e.cyc + 3));
                end
            end else begin
                chk("eof_idle", 32'(eof), 32'd0);
            end
        end
    end

    function automatic int qf(input logic [15:0] d);
        int v;
        v = int'($signed(d));
        if (v <= -21) return -4;
        if (v <= -7)  return -3;
        if (v <= -3)  return -2;
        if (v < 0)    return -1;
        if (v == 0)   return 0;
        if (v < 3)    return 1;
        if (v < 7)    return 2;
        if (v < 21)   return 3;
        return 4;
    endfunction

    task automatic model(input logic [15:0] x, a, b, c, g1, g2, g3,
                         output logic [8:0] ctx, output logic sg,
                         output logic [15:0] p, output logic [15:0] ev);
        int q1, q2, q3, mn, mx, pi, e;
        q1 = qf(g1);
        q2 = qf(g2);
        q3 = qf(g3);
        sg = (q1 < 0) || (q1 == 0 && q2 < 0) ||
             (q1 == 0 && q2 == 0 && q3 < 0);
        if (sg) begin
            q1 = -q1;
            q2 = -q2;
            q3 = -q3;
        end
        ctx = 9'(81 * q1 + 9 * q2 + q3);
        mn  = (int'(a) < int'(b)) ? int'(a) : int'(b);
        mx  = (int'(a) < int'(b)) ? int'(b) : int'(a);
        if (int'(c) >= mx)      pi = mn;
        else if (int'(c) <= mn) pi = mx;
        else                    pi = int'(a) + int'(b) - int'(c);
        e = int'(x) - pi;
        if (sg)       e = -e;
        if (e < 0)    e = e + 256;
        if (e >= 128) e = e - 256;
        p  = 16'(pi);
        ev = 16'(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] x, a, b, c, g1, g2, g3);
        in_valid = 1'b1;
        rx = x; ra = a; rb = b; rc = c;
        d1 = g1; d2 = g2; d3 = g3;
    endtask

    task automatic expect_out(input logic [8:0] ctx, input logic sg,
                              input logic [15:0] p, input logic [15:0] ev,
                              input logic [15:0] a, input logic run);
        exp_t e;
        e.ctx = ctx; e.sg = sg; e.p = p; e.ev = ev;
        e.a = a; e.run = run;
        e.eof = (pix == NPIX - 1);
        e.cyc = cyc;
        pix = (pix == NPIX - 1) ? 0 : pix + 1;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        rx = 'x; ra = 'x; rb = 'x; rc = 'x;
        d1 = 'x; d2 = 'x; d3 = 'x;
        repeat (n) step();
    endtask

    task automatic send_rand();
        logic [15:0] x, a, b, c, g1, g2, g3, p, ev;
        logic [8:0]  ctx;
        logic        sg;
        x  = 16'($urandom_range(0, 255));
        a  = 16'($urandom_range(0, 255));
        b  = 16'($urandom_range(0, 255));
        c  = 16'($urandom_range(0, 255));
        g1 = 16'($urandom_range(0, 80)) - 16'd40;
        g2 = 16'($urandom_range(0, 80)) - 16'd40;
        g3 = 16'($urandom_range(0, 80)) - 16'd40;
        if ($urandom_range(0, 4) == 0) begin
            g1 = '0; g2 = '0; g3 = '0;
        end
        drive(x, a, b, c, g1, g2, g3);
        model(x, a, b, c, g1, g2, g3, ctx, sg, p, ev);
        expect_out(ctx, sg, p, ev, a,
                   (g1 == 0) && (g2 == 0) && (g3 == 0));
        step();
    endtask

    task automatic chk_cleared(input string tag);
        @(negedge clk);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_eof"},       32'(eof),       32'd0);
        chk({tag, "_ctx_q"},     32'(ctx_q),     32'd0);
        chk({tag, "_ctx_sign"},  32'(ctx_sign),  32'd0);
        chk({tag, "_px"},        32'(px),        32'd0);
        chk({tag, "_errval"},    32'(errval),    32'd0);
        chk({tag, "_ra_out"},    32'(ra_out),    32'd0);
        chk({tag, "_run_mode"},  32'(run_mode),  32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle(0);
        repeat (3) @(posedge clk);
        chk_cleared("reset");
        step();
        rst = 1'b0;

        // flat neighbourhood: run mode, zero context
        drive(100, 100, 100, 100, 0, 0, 0);
        expect_out(0, 0, 100, 0, 100, 1);
        step();
        // positive and mirrored gradient share context 162
        drive(100, 100, 100, 100, 16'd5, 0, 0);
        expect_out(162, 0, 100, 0, 100, 0);
        step();
        drive(100, 100, 100, 100, 16'hFFFB, 0, 0);
        expect_out(162, 1, 100, 0, 100, 0);
        step();
        idle(2);
        // MED: edge above, edge below, planar
        drive(10, 10, 20, 25, 0, 0, 0);
        expect_out(0, 0, 10, 0, 10, 1);
        step();
        drive(20, 10, 20, 5, 0, 0, 0);
        expect_out(0, 0, 20, 0, 10, 1);
        step();
        drive(12, 10, 20, 15, 0, 0, 0);
        expect_out(0, 0, 15, 16'hFFFD, 10, 1);
        step();
        // modulo wrap in both directions
        drive(250, 0, 0, 0, 0, 0, 0);
        expect_out(0, 0, 0, 16'hFFFA, 0, 1);
        step();
        idle(1);
        drive(0, 255, 255, 255, 0, 0, 0);
        expect_out(0, 0, 255, 16'd1, 255, 1);
        step();
        // negated context also negates the error
        drive(103, 100, 100, 100, 16'hFFFB, 0, 0);
        expect_out(162, 1, 100, 16'hFFFD, 100, 0);
        step();

        // random traffic with gaps spans two frame boundaries
        for (int i = 0; i < 30; i++) begin
            send_rand();
            idle($urandom_range(0, 3));
        end
        idle(6);

        // reset with the pipeline full
        for (int i = 0; i < 3; i++) send_rand();
        rst = 1'b1;
        idle(0);
        step();
        q.delete();
        pix = 0;
        chk_cleared("midreset");
        step();
        rst = 1'b0;

        // first pixel right after release is pixel 0 of a new frame
        for (int i = 0; i < 17; i++) begin
            send_rand();
            idle($urandom_range(0, 3));
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        idle(2);
        chk("drain", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
